// File: rtl/iob_master.sv
// iob_master: master-side sequencer for the slow 68000-style I/O bus.
// Takes one read/write request at a time from the FSB bridge, runs the
// AS/DS/RnW handshake on emulated C8M ticks, supports DTACK, VPA/E-clock
// and BERR/timeout termination, and reports IOACT/IODONEout/IOBERR back.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus quiet, waiting for IORDREQ/IOWRREQ
// S0      | request latched, waiting for tick to drive AS (and read DS)
// S2      | AS driven, waiting for tick to drive write DS
// WAIT    | strobes out, waiting for BERR/DTACK/VPA or timeout
// VPA1    | VPA seen, waiting for E count 3 to assert VMA
// VPA2    | VMA asserted, waiting for E to fall
// S6      | terminated, waiting for tick to negate strobes
// REC     | recovery tick, then report DONE/BERR and release bridge
module iob_master #(
    parameter int CLKDIV  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic nRES,
    input  logic IORDREQ,
    input  logic IOWRREQ,
    input  logic IOL0,
    input  logic IOU0,
    output logic IOACT,
    output logic IODONEout,
    output logic IOBERR,
    input  logic nDTACK,
    input  logic nVPA,
    input  logic nBERR_IOB,
    output logic nAS_IOB,
    output logic nLDS_IOB,
    output logic nUDS_IOB,
    output logic RnW_IOB,
    output logic E,
    output logic nVMA_IOB,
    output logic nDoutOE,
    output logic DinLE,
    output logic ALE0M
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_S0, ST_S2, ST_WAIT, ST_VPA1, ST_VPA2, ST_S6, ST_REC
    } state_t;

    localparam logic [3:0] TICK_LAST = 4'(CLKDIV - 1);

    state_t     state, state_d;
    logic [3:0] tick_cnt;
    logic       tick;
    logic [3:0] e_cnt;
    logic [2:0] sync1, sync2;
    logic       berr_s, dtack_s, vpa_s;
    logic       rnw_q, l_q, u_q, err_q;
    logic       rnw_d, l_d, u_d, err_d;
    logic [7:0] to_cnt, to_d;
    logic [8:0] to_inc;
    logic       act_d, done_d, berr_d, as_d, lds_d, uds_d, rw_d, vma_d, oe_d, dinle_d, ale_d;

    assign tick = (tick_cnt == TICK_LAST);
    assign E    = (e_cnt >= 4'd6);

    assign berr_s  = !sync2[2];
    assign dtack_s = !sync2[1];
    assign vpa_s   = !sync2[0];

    // Free-running tick divider and the 10-state E clock counter it drives.
    always_ff @(posedge CLK) begin
        if (!nRES) begin
            tick_cnt <= 4'd0;
            e_cnt    <= 4'd0;
        end else begin
            tick_cnt <= tick ? 4'd0 : tick_cnt + 4'd1;
            if (tick)
                e_cnt <= (e_cnt == 4'd9) ? 4'd0 : e_cnt + 4'd1;
        end
    end

    // Two-flop synchronizers for the asynchronous bus terminations.
    always_ff @(posedge CLK) begin
        if (!nRES) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= {nBERR_IOB, nDTACK, nVPA};
            sync2 <= sync1;
        end
    end

    // Next-state and next-output decode; strobes only change on ticks.
    always_comb begin
        state_d = state;
        rnw_d   = rnw_q;
        l_d     = l_q;
        u_d     = u_q;
        err_d   = err_q;
        to_d    = to_cnt;
        act_d   = IOACT;
        done_d  = IODONEout;
        berr_d  = IOBERR;
        as_d    = nAS_IOB;
        lds_d   = nLDS_IOB;
        uds_d   = nUDS_IOB;
        rw_d    = RnW_IOB;
        vma_d   = nVMA_IOB;
        oe_d    = nDoutOE;
        dinle_d = 1'b0;
        ale_d   = ALE0M;
        to_inc  = {1'b0, to_cnt} + 9'd1;
        case (state)
            ST_IDLE: begin
                if (IORDREQ || IOWRREQ) begin
                    rnw_d   = IORDREQ;
                    l_d     = IOL0;
                    u_d     = IOU0;
                    err_d   = 1'b0;
                    act_d   = 1'b1;
                    ale_d   = 1'b1;
                    done_d  = 1'b0;
                    berr_d  = 1'b0;
                    state_d = ST_S0;
                end
            end
            ST_S0: begin
                if (tick) begin
                    as_d = 1'b0;
                    rw_d = rnw_q;
                    if (rnw_q) begin
                        lds_d = !l_q;
                        uds_d = !u_q;
                    end else begin
                        oe_d = 1'b0;
                    end
                    state_d = ST_S2;
                end
            end
            ST_S2: begin
                if (tick) begin
                    if (!rnw_q) begin
                        lds_d = !l_q;
                        uds_d = !u_q;
                    end
                    to_d    = 8'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    if (berr_s) begin
                        err_d   = 1'b1;
                        state_d = ST_S6;
                    end else if (dtack_s) begin
                        dinle_d = rnw_q && !err_q;
                        state_d = ST_S6;
                    end else if (vpa_s) begin
                        state_d = ST_VPA1;
                    end else begin
                        to_d = to_inc[7:0];
                        if (to_inc == 9'(TIMEOUT)) begin
                            err_d   = 1'b1;
                            state_d = ST_S6;
                        end
                    end
                end
            end
            ST_VPA1: begin
                if (tick && e_cnt == 4'd2) begin
                    vma_d   = 1'b0;
                    state_d = ST_VPA2;
                end
            end
            ST_VPA2: begin
                if (tick && e_cnt == 4'd9) begin
                    dinle_d = rnw_q && !err_q;
                    state_d = ST_S6;
                end
            end
            ST_S6: begin
                if (tick) begin
                    as_d    = 1'b1;
                    lds_d   = 1'b1;
                    uds_d   = 1'b1;
                    vma_d   = 1'b1;
                    oe_d    = 1'b1;
                    rw_d    = 1'b1;
                    state_d = ST_REC;
                end
            end
            ST_REC: begin
                if (tick) begin
                    act_d   = 1'b0;
                    ale_d   = 1'b0;
                    done_d  = !err_q;
                    berr_d  = err_q;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched request attributes and registered bus outputs.
    always_ff @(posedge CLK) begin
        if (!nRES) begin
            state     <= ST_IDLE;
            rnw_q     <= 1'b1;
            l_q       <= 1'b0;
            u_q       <= 1'b0;
            err_q     <= 1'b0;
            to_cnt    <= 8'd0;
            IOACT     <= 1'b0;
            IODONEout <= 1'b0;
            IOBERR    <= 1'b0;
            nAS_IOB   <= 1'b1;
            nLDS_IOB  <= 1'b1;
            nUDS_IOB  <= 1'b1;
            RnW_IOB   <= 1'b1;
            nVMA_IOB  <= 1'b1;
            nDoutOE   <= 1'b1;
            DinLE     <= 1'b0;
            ALE0M     <= 1'b0;
        end else begin
            state     <= state_d;
            rnw_q     <= rnw_d;
            l_q       <= l_d;
            u_q       <= u_d;
            err_q     <= err_d;
            to_cnt    <= to_d;
            IOACT     <= act_d;
            IODONEout <= done_d;
            IOBERR    <= berr_d;
            nAS_IOB   <= as_d;
            nLDS_IOB  <= lds_d;
            nUDS_IOB  <= uds_d;
            RnW_IOB   <= rw_d;
            nVMA_IOB  <= vma_d;
            nDoutOE   <= oe_d;
            DinLE     <= dinle_d;
            ALE0M     <= ale_d;
        end
    end

endmodule

// File: tb/tb_iob_master.sv
// Bench for iob_master with CLKDIV=2, TIMEOUT=4: table of bus cycles with a
// scoreboard of expected outcomes, plus hand sequences for delayed DTACK,
// back-to-back requests and reset in the middle of a cycle.
module tb_iob_master;

    localparam int T_DTACK = 0;
    localparam int T_VPA   = 1;
    localparam int T_BERR  = 2;
    localparam int T_NONE  = 3;
    localparam int T_BOTH  = 4;

    typedef struct {
        bit rd;
        bit wr;
        bit l;
        bit u;
        int term;
        bit exp_done;
        bit exp_berr;
        int exp_din;
        int exp_width;
    } vec_t;

    logic CLK = 0, nRES = 0;
    logic IORDREQ = 0, IOWRREQ = 0, IOL0 = 0, IOU0 = 0;
    logic nDTACK = 1, nVPA = 1, nBERR_IOB = 1;
    logic IOACT, IODONEout, IOBERR, nAS_IOB, nLDS_IOB, nUDS_IOB, RnW_IOB;
    logic E, nVMA_IOB, nDoutOE, DinLE, ALE0M;

    int errors = 0, checks = 0;
    vec_t vecs[8];
    vec_t sb[$];

    int m_lat, m_as_f, m_as_r, m_lds_f, m_uds_f, m_oe_f, m_vma_f, m_e_r, m_e_f;
    int m_din, m_viol, m_rnw, m_end;
    bit m_tmo, m_done, m_berr;

    iob_master #(.CLKDIV(2), .TIMEOUT(4)) dut (
        .CLK(CLK), .nRES(nRES),
        .IORDREQ(IORDREQ), .IOWRREQ(IOWRREQ), .IOL0(IOL0), .IOU0(IOU0),
        .IOACT(IOACT), .IODONEout(IODONEout), .IOBERR(IOBERR),
        .nDTACK(nDTACK), .nVPA(nVPA), .nBERR_IOB(nBERR_IOB),
        .nAS_IOB(nAS_IOB), .nLDS_IOB(nLDS_IOB), .nUDS_IOB(nUDS_IOB),
        .RnW_IOB(RnW_IOB), .E(E), .nVMA_IOB(nVMA_IOB), .nDoutOE(nDoutOE),
        .DinLE(DinLE), .ALE0M(ALE0M)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_term(input int t);
        nDTACK    = !(t == T_DTACK || t == T_BOTH);
        nVPA      = !(t == T_VPA);
        nBERR_IOB = !(t == T_BERR || t == T_BOTH);
    endtask

    task automatic do_reset();
        nRES = 0;
        repeat (3) @(negedge CLK);
        nRES = 1;
    endtask

    // Drive one request and record when each bus signal moves, in negedge
    // counts from the drive point, until IOACT drops again.
    task automatic run_txn(input bit rd, input bit wr, input bit l, input bit u,
                           input int dly, input bit hold);
        int n;
        bit seen, pe;
        m_lat = -1; m_as_f = -1; m_as_r = -1; m_lds_f = -1; m_uds_f = -1;
        m_oe_f = -1; m_vma_f = -1; m_e_r = -1; m_e_f = -1;
        m_din = 0; m_viol = 0; m_rnw = -1; m_tmo = 0;
        IORDREQ = rd; IOWRREQ = wr; IOL0 = l; IOU0 = u;
        n = 0; seen = 0; pe = E;
        while (1) begin
            @(negedge CLK);
            n++;
            if (n > 300) begin
                m_tmo = 1;
                break;
            end
            if (IOACT && !seen) begin
                seen = 1;
                m_lat = n;
                if (!hold) begin
                    IORDREQ = 0;
                    IOWRREQ = 0;
                end
            end
            if (!nAS_IOB && m_as_f < 0) begin
                m_as_f = n;
                m_rnw  = int'(RnW_IOB);
            end
            if (nAS_IOB && m_as_f >= 0 && m_as_r < 0) m_as_r = n;
            if (!nLDS_IOB && m_lds_f < 0) m_lds_f = n;
            if (!nUDS_IOB && m_uds_f < 0) m_uds_f = n;
            if (!nDoutOE && m_oe_f < 0) m_oe_f = n;
            if (!nVMA_IOB && m_vma_f < 0) m_vma_f = n;
            if (E && !pe && m_vma_f >= 0 && m_e_r < 0) m_e_r = n;
            if (!E && pe && !nAS_IOB) m_e_f = n;
            if (DinLE) m_din++;
            if (!IOACT && !(nAS_IOB && nLDS_IOB && nUDS_IOB)) m_viol++;
            if (ALE0M != IOACT) m_viol++;
            if (dly >= 0 && m_as_f >= 0 && n == m_as_f + dly) nDTACK = 0;
            pe = E;
            if (seen && !IOACT) break;
        end
        m_end  = n;
        m_done = IODONEout;
        m_berr = IOBERR;
    endtask

    initial begin
        int exp_ds, n;
        vec_t v;

        //          rd wr  l  u  term     done berr din width
        vecs[0] = '{1, 0, 1, 0, T_DTACK, 1, 0, 1, 6};
        vecs[1] = '{0, 1, 1, 1, T_DTACK, 1, 0, 0, 6};
        vecs[2] = '{1, 0, 0, 1, T_VPA,   1, 0, 1, -1};
        vecs[3] = '{1, 0, 1, 1, T_NONE,  0, 1, 0, 12};
        vecs[4] = '{0, 1, 0, 1, T_BERR,  0, 1, 0, 6};
        vecs[5] = '{1, 0, 1, 1, T_BOTH,  0, 1, 0, 6};
        vecs[6] = '{0, 1, 1, 0, T_VPA,   1, 0, 0, -1};
        vecs[7] = '{1, 1, 1, 1, T_DTACK, 1, 0, 1, 6};

        do_reset();
        @(negedge CLK);
        chk("reset_outputs",
            int'({nAS_IOB, nLDS_IOB, nUDS_IOB, RnW_IOB, nVMA_IOB, nDoutOE,
                  IOACT, IODONEout, IOBERR, DinLE, ALE0M, E}),
            int'(12'b111111_000000));

        for (int i = 0; i < 8; i++) begin
            set_term(vecs[i].term);
            repeat (4) @(negedge CLK);
            sb.push_back(vecs[i]);
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].l, vecs[i].u, -1, 0);
            set_term(T_NONE);
            v = sb.pop_front();
            chk($sformatf("v%0d_no_hang", i), int'(m_tmo), 0);
            chk($sformatf("v%0d_latency", i), m_lat, 1);
            chk($sformatf("v%0d_rnw", i), m_rnw, int'(v.rd));
            exp_ds = v.rd ? m_as_f : m_as_f + 2;
            chk($sformatf("v%0d_lds", i), m_lds_f, v.l ? exp_ds : -1);
            chk($sformatf("v%0d_uds", i), m_uds_f, v.u ? exp_ds : -1);
            chk($sformatf("v%0d_doutoe", i), m_oe_f, v.rd ? -1 : m_as_f);
            chk($sformatf("v%0d_done", i), int'(m_done), int'(v.exp_done));
            chk($sformatf("v%0d_berr", i), int'(m_berr), int'(v.exp_berr));
            chk($sformatf("v%0d_dinle", i), m_din, v.exp_din);
            if (v.exp_width >= 0)
                chk($sformatf("v%0d_as_width", i), m_as_r - m_as_f, v.exp_width);
            else
                chk($sformatf("v%0d_as_width_bound", i), int'(m_as_r - m_as_f <= 44), 1);
            chk($sformatf("v%0d_vma_seen", i), int'(m_vma_f >= 0), int'(v.term == T_VPA));
            if (v.term == T_VPA) begin
                chk($sformatf("v%0d_vma_to_erise", i), m_e_r - m_vma_f, 6);
                chk($sformatf("v%0d_efall_to_asrise", i), m_as_r - m_e_f, 2);
            end
            chk($sformatf("v%0d_act_strobe_viol", i), m_viol, 0);
            chk($sformatf("v%0d_rec_tick", i), m_end - m_as_r, 2);
            if (m_tmo) do_reset();
            repeat (4) @(negedge CLK);
        end

        // Read with DTACK arriving on the third WAIT tick.
        set_term(T_NONE);
        repeat (4) @(negedge CLK);
        run_txn(1, 0, 1, 0, 4, 0);
        nDTACK = 1;
        chk("late_dtack_done", int'(m_done), 1);
        chk("late_dtack_berr", int'(m_berr), 0);
        chk("late_dtack_width", m_as_r - m_as_f, 10);
        chk("late_dtack_dinle", m_din, 1);
        chk("late_dtack_uds", m_uds_f, -1);
        repeat (4) @(negedge CLK);

        // Back-to-back writes: request held through REC of a BERR cycle.
        set_term(T_BERR);
        repeat (4) @(negedge CLK);
        run_txn(0, 1, 1, 1, -1, 1);
        set_term(T_DTACK);
        chk("b2b_first_berr", int'(m_berr), 1);
        @(negedge CLK);
        IOWRREQ = 0;
        chk("b2b_reaccept", int'(IOACT), 1);
        chk("b2b_flags_cleared", int'({IOBERR, IODONEout}), 0);
        n = 0;
        while (IOACT && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("b2b_second_finished", int'(n < 200), 1);
        chk("b2b_second_done", int'({IODONEout, IOBERR}), 2);
        set_term(T_NONE);
        repeat (4) @(negedge CLK);

        // Reset while strobes are out in WAIT, then a normal cycle.
        IORDREQ = 1; IOL0 = 1; IOU0 = 1;
        n = 0;
        while (nAS_IOB && n < 20) begin
            @(negedge CLK);
            n++;
            if (IOACT) IORDREQ = 0;
        end
        IORDREQ = 0;
        repeat (4) @(negedge CLK);
        chk("rst_strobes_before", int'({nAS_IOB, nLDS_IOB, nUDS_IOB, IOACT}), 1);
        nRES = 0;
        @(negedge CLK);
        chk("rst_midcycle",
            int'({nAS_IOB, nLDS_IOB, nUDS_IOB, IOACT, IODONEout, IOBERR}),
            int'(6'b111000));
        nRES = 1;
        set_term(T_DTACK);
        repeat (4) @(negedge CLK);
        run_txn(1, 0, 0, 1, -1, 0);
        set_term(T_NONE);
        chk("post_rst_done", int'({m_done, m_berr}), 2);
        chk("post_rst_dinle", m_din, 1);
        chk("post_rst_latency", m_lat, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iob_master.md
Name: iob_master

Overview:
- Master-side sequencer for the slow 68000-style I/O bus behind the FSB I/O bridge.
- Accepts one-cycle-at-a-time read/write requests (IORDREQ/IOWRREQ plus latched strobe selects IOL0/IOU0) from the bridge's FIFO primary level.
- Generates I/O-bus AS/LDS/UDS/R/W, the E clock and VMA, and data-latch/output-enable controls.
- Terminates each cycle on DTACK, VPA (E-synchronous) or BERR/timeout, and reports IOACT/IODONE/IOBERR back to the bridge.

Parameters:
- CLKDIV, 2, CLK cycles per I/O-bus tick (emulated C8M half-period); legal 1..15
- TIMEOUT, 255, ticks in WAIT with no termination before forced bus error; legal 1..255

Ports:
- CLK  in  1  system clock, all logic on rising edge
- nRES  in  1  reset; synchronous, active-low
- IORDREQ  in  1  read request from bridge, level, held until IOACT seen
- IOWRREQ  in  1  write request from bridge, level, held until IOACT seen
- IOL0  in  1  low byte select for requested cycle
- IOU0  in  1  high byte select for requested cycle
- IOACT  out  1  cycle accepted/in progress
- IODONEout  out  1  last cycle terminated normally
- IOBERR  out  1  last cycle terminated with bus error
- nDTACK  in  1  async I/O-bus DTACK
- nVPA  in  1  async I/O-bus VPA
- nBERR_IOB  in  1  async I/O-bus BERR
- nAS_IOB  out  1  I/O-bus address strobe
- nLDS_IOB  out  1  I/O-bus lower data strobe
- nUDS_IOB  out  1  I/O-bus upper data strobe
- RnW_IOB  out  1  I/O-bus read/not-write
- E  out  1  6800 E clock
- nVMA_IOB  out  1  valid memory address
- nDoutOE  out  1  drive write data onto I/O bus
- DinLE  out  1  one-CLK pulse: latch I/O-bus read data
- ALE0M  out  1  keep FIFO primary address latch closed while master owns it

Behaviour:
- Reset (nRES=0 at an edge): all strobes, nVMA and nDoutOE go 1 (negated); RnW=1; IOACT, IODONEout, IOBERR, DinLE, ALE0M, E = 0; tick and E counters = 0; state = IDLE.
- Reset mid-cycle aborts the cycle at that edge. No DONE/BERR is reported.
- Tick: free-running counter 0..CLKDIV-1; tick=1 in the cycle the counter equals CLKDIV-1.
- E: counter 0..9 advances on ticks; E=1 for counts 6..9, otherwise 0.
- Sync: nDTACK, nVPA and nBERR_IOB each go through a 2-flop synchronizer. Only synchronized values are used.
- IDLE:
  - Any edge with IORDREQ|IOWRREQ: latch RnW=IORDREQ (both set → read), latch L=IOL0, U=IOU0.
  - Same edge: IOACT←1, ALE0M←1, IODONEout←0, IOBERR←0 → S0. Latency 1 CLK.
- S0: wait for next tick.
  - At that tick: nAS←0, RnW_IOB←RnW.
  - Read: also assert the latched data strobes.
  - Write: nDoutOE←0.
  - → S2.
- S2 at tick: write asserts the latched data strobes. → WAIT. Clear timeout counter.
- WAIT, evaluated on ticks with priority BERR > DTACK > VPA > timeout:
  - BERR: err←1 → S6.
  - DTACK: → S6.
  - VPA: → VPA1.
  - Otherwise increment timeout; when it reaches TIMEOUT, err←1 → S6.
- VPA1: on the tick where E count becomes 3, nVMA←0 → VPA2.
- VPA2: on the tick where E count becomes 0 (E falling), → S6.
- S6:
  - Read with no error: DinLE=1 for exactly one CLK at the entering edge.
  - At the next tick: negate nAS, nLDS, nUDS, nVMA and nDoutOE; RnW_IOB←1. → REC.
- REC at tick:
  - IOACT←0, ALE0M←0.
  - IODONEout←!err, IOBERR←err; clear err. → IDLE.
- IODONEout/IOBERR hold until the next request is accepted.
- IOACT is never 0 while any strobe is asserted.
- A request already asserted when REC finishes is accepted on the first IDLE edge, which is back-to-back.
- Requests that arrive while IOACT=1 are ignored (the bridge withdraws REQ on IOACT).
- Exactly one of IODONEout/IOBERR is set per completed cycle.

Test Plan:
- Read, CLKDIV=2, IOL0=1, IOU0=0, DTACK 3 ticks after S2:
  - IOACT=1 one CLK after IORDREQ.
  - nAS_IOB and nLDS_IOB low together; nUDS_IOB stays high.
  - DinLE is a single 1-CLK pulse.
  - IODONEout=1 and IOACT=0 at REC; IOBERR=0.
- Word write, both strobes, DTACK immediate:
  - nDoutOE low at AS assertion.
  - DS low one tick later.
  - No DinLE; IODONEout=1.
- VPA read:
  - nVMA_IOB falls only as E count reaches 3.
  - Strobes negate one tick after E falls.
  - Total cycle length ≤ 10 ticks + overhead.
- No termination, TIMEOUT=4: IOBERR=1 after exactly 4 WAIT ticks, IODONEout=0, no DinLE. Repeat with nBERR_IOB and nDTACK asserted on the same tick → IOBERR=1.
- Back-to-back: IOWRREQ held through REC → new cycle IOACT reasserts one CLK after REC; IOBERR/IODONEout from the prior cycle cleared at acceptance.
- nRES pulled low in WAIT with strobes asserted → all strobes high, IOACT=0, IODONEout=0 at the next edge. After release, a new request runs normally.
